// File: rtl/wb_openram_pkg.sv
// wb_openram_pkg: shared constants and FSM encodings for the Wishbone/OpenRAM bank controller
package wb_openram_pkg;
    localparam int MAX_BANKS      = 4;
    localparam int BANK_SEL_WIDTH = 2;
    localparam int WORD_WIDTH     = 32;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;
endpackage

// File: rtl/wb_openram_rdmux.sv
// wb_openram_rdmux: registered selection of one bank's read data, updated only on capture
module wb_openram_rdmux
    import wb_openram_pkg::*;
#(
    parameter int BANK_COUNT = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_cap,
    input  logic [BANK_SEL_WIDTH-1:0]        i_bank,
    input  logic [WORD_WIDTH*BANK_COUNT-1:0] i_dout,
    output logic [WORD_WIDTH-1:0]            o_dat
);
    logic [WORD_WIDTH-1:0] w_words [MAX_BANKS];
    logic [WORD_WIDTH-1:0] r_dat;

    // Unpopulated banks read as zero so the select never indexes past the bus
    for (genvar b = 0; b < MAX_BANKS; b++) begin : g_w
        if (b < BANK_COUNT) begin : g_p
            assign w_words[b] = i_dout[WORD_WIDTH*b +: WORD_WIDTH];
        end else begin : g_z
            assign w_words[b] = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_dat <= '0;
        else if (i_cap) r_dat <= w_words[i_bank];

    assign o_dat = r_dat;
endmodule

// File: rtl/wb_openram_bank_ctrl.sv
// wb_openram_bank_ctrl: Wishbone classic slave fronting up to four single-port OpenRAM banks
module wb_openram_bank_ctrl
    import wb_openram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter int          BANK_COUNT      = 2,
    parameter int          BANK_ADDR_WIDTH = 8,
    parameter int          READ_LATENCY    = 1
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_n_i,
    input  logic [BANK_COUNT-1:0]            read_only_i,
    input  logic                             wbs_stb_i,
    input  logic                             wbs_cyc_i,
    input  logic                             wbs_we_i,
    input  logic [3:0]                       wbs_sel_i,
    input  logic [31:0]                      wbs_adr_i,
    input  logic [31:0]                      wbs_dat_i,
    output logic [31:0]                      wbs_dat_o,
    output logic                             wbs_ack_o,
    output logic                             wbs_err_o,
    output logic [BANK_COUNT-1:0]            ram_csb,
    output logic                             ram_web,
    output logic [3:0]                       ram_wmask,
    output logic [BANK_ADDR_WIDTH-1:0]       ram_addr,
    output logic [31:0]                      ram_din,
    input  logic [WORD_WIDTH*BANK_COUNT-1:0] ram_dout
);
    localparam logic [31:0] WIN_MASK = ~((32'd1 << (BANK_ADDR_WIDTH + 4)) - 32'd1);

    logic                       w_hit, w_req, w_bad, w_cap;
    logic [BANK_SEL_WIDTH-1:0]  w_bank;
    logic [BANK_ADDR_WIDTH-1:0] w_word;
    logic [MAX_BANKS-1:0]       w_ro;

    logic [1:0]                 r_state;
    logic [1:0]                 r_cnt;
    logic                       r_we, r_abort, r_ack, r_err, r_web;
    logic [BANK_SEL_WIDTH-1:0]  r_bank;
    logic [BANK_COUNT-1:0]      r_csb;
    logic [3:0]                 r_wmask;
    logic [BANK_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]                r_din;

    assign w_hit  = (wbs_adr_i & WIN_MASK) == BASE_ADDR;
    assign w_req  = wbs_stb_i && wbs_cyc_i && w_hit;
    assign w_bank = wbs_adr_i[BANK_ADDR_WIDTH+3 -: BANK_SEL_WIDTH];
    assign w_word = wbs_adr_i[BANK_ADDR_WIDTH+1:2];
    assign w_ro   = MAX_BANKS'(read_only_i);
    assign w_bad  = (32'(w_bank) >= 32'(BANK_COUNT)) || (wbs_we_i && w_ro[w_bank]);
    assign w_cap  = (r_state == S_WAIT) && (r_cnt == 2'd1);

    // RAM strobes default to idle every cycle; only the IDLE->ACCESS edge drives them active
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_abort <= 1'b0;
            r_bank  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_csb   <= '1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
        end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_csb   <= '1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_we    <= wbs_we_i;
                    r_bank  <= w_bank;
                    r_abort <= 1'b0;
                    if (w_bad) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_csb   <= ~(BANK_COUNT'(1) << w_bank);
                        r_addr  <= w_word;
                        r_web   <= ~wbs_we_i;
                        r_wmask <= wbs_we_i ? wbs_sel_i : 4'h0;
                        if (wbs_we_i) r_din <= wbs_dat_i;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= 2'(READ_LATENCY);
                    if (r_we) begin
                        r_ack   <= wbs_cyc_i;
                        r_state <= wbs_cyc_i ? S_RESP : S_IDLE;
                    end else begin
                        r_abort <= !wbs_cyc_i;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (!wbs_cyc_i) r_abort <= 1'b1;
                    if (r_cnt == 2'd1) begin
                        r_ack   <= wbs_cyc_i && !r_abort;
                        r_state <= (wbs_cyc_i && !r_abort) ? S_RESP : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    wb_openram_rdmux #(.BANK_COUNT(BANK_COUNT)) u_rdmux (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_n_i),
        .i_cap   (w_cap),
        .i_bank  (r_bank),
        .i_dout  (ram_dout),
        .o_dat   (wbs_dat_o)
    );

    assign wbs_ack_o = r_ack;
    assign wbs_err_o = r_err;
    assign ram_csb   = r_csb;
    assign ram_web   = r_web;
    assign ram_wmask = r_wmask;
    assign ram_addr  = r_addr;
    assign ram_din   = r_din;
endmodule

// File: tb/tb_wb_openram_bank_ctrl.sv
// tb_wb_openram_bank_ctrl: directed Wishbone traffic against a two-bank RAM model with a response scoreboard
module tb_wb_openram_bank_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int RL = 2;

    typedef struct {
        logic        kind;
        logic        chk;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  read_only = 2'b00;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat_i = '0;
    logic [31:0] dat_o;
    logic        ack, err;
    logic [1:0]  ram_csb;
    logic        ram_web;
    logic [3:0]  ram_wmask;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic [63:0] ram_dout;

    logic [31:0] mem [2][256];
    logic [31:0] pipe0 [2];
    logic [31:0] pipe1 [2];

    exp_t q[$];
    int cyc_n = 0;
    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;
    logic [1:0]  s1_csb, s2_csb;
    logic        s1_web;
    logic [3:0]  s1_wmask, s2_wmask;
    logic [7:0]  s1_addr;
    logic [31:0] s1_din;

    wb_openram_bank_ctrl #(
        .BASE_ADDR(BASE), .BANK_COUNT(2), .BANK_ADDR_WIDTH(8), .READ_LATENCY(RL)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .read_only_i(read_only),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o),
        .wbs_ack_o(ack), .wbs_err_o(err),
        .ram_csb(ram_csb), .ram_web(ram_web), .ram_wmask(ram_wmask),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Single-port RAM model: write at the capture edge, read data emerges RL cycles later
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!ram_csb[b]) begin
                if (!ram_web) begin
                    for (int j = 0; j < 4; j++)
                        if (ram_wmask[j]) mem[b][ram_addr][8*j +: 8] <= ram_din[8*j +: 8];
                end else pipe0[b] <= mem[b][ram_addr];
            end
            pipe1[b] <= pipe0[b];
        end
    end
    always_comb ram_dout = {pipe1[1], pipe1[0]};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) check("csb_onehot", 64'($countones(~ram_csb) <= 1), 64'd1);
        if (ack || err) begin
            resp_cnt++;
            check("ack_err_excl", 64'(ack && err), 64'd0);
            if (q.size() == 0) check("unexpected_resp", {62'd0, ack, err}, 64'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("resp_kind", 64'(err), 64'(e.kind));
                check("resp_cycle", 64'(cyc_n), 64'(e.cyc));
                if (e.chk) check("rdata", 64'(dat_o), 64'(e.dat));
            end
        end
    end

    task automatic wb_req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          input logic is_err, input logic chk, input logic [31:0] edat);
        int n;
        exp_t e;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        e.kind = is_err;
        e.chk = chk;
        e.dat = edat;
        e.cyc = cyc_n + (is_err ? 1 : (w ? 2 : 2 + RL));
        q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                s1_csb = ram_csb; s1_web = ram_web; s1_wmask = ram_wmask; s1_addr = ram_addr; s1_din = ram_din;
            end
            if (n == 2) begin
                s2_csb = ram_csb; s2_wmask = ram_wmask;
            end
        end while (!(ack || err) && n < 20);
        if (!(ack || err)) check("resp_timeout", 64'd0, 64'd1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic hold_none(input string name, input int n);
        int c0;
        c0 = resp_cnt;
        repeat (n) @(negedge clk);
        check(name, 64'(resp_cnt), 64'(c0));
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            pipe0[b] = '0;
            pipe1[b] = '0;
            for (int i = 0; i < 256; i++) mem[b][i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_csb", 64'(ram_csb), 64'h3);
        check("rst_web", 64'(ram_web), 64'h1);
        check("rst_wmask", 64'(ram_wmask), 64'h0);
        check("rst_addr", 64'(ram_addr), 64'h0);
        check("rst_din", 64'(ram_din), 64'h0);
        check("rst_dat_o", 64'(dat_o), 64'h0);
        check("rst_ack_err", {62'd0, ack, err}, 64'h0);
        rst_n = 1'b1;

        wb_req(1'b1, BASE + 32'h404, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
        check("w1_csb", 64'(s1_csb), 64'h1);
        check("w1_web", 64'(s1_web), 64'h0);
        check("w1_addr", 64'(s1_addr), 64'h1);
        check("w1_wmask", 64'(s1_wmask), 64'hF);
        check("w1_din", 64'(s1_din), 64'hDEAD_BEEF);
        check("w1_wmask_after", 64'(s2_wmask), 64'h0);

        wb_req(1'b0, BASE + 32'h404, 4'h0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check("r1_web", 64'(s1_web), 64'h1);
        check("r1_wmask", 64'(s1_wmask), 64'h0);
        check("r1_csb", 64'(s1_csb), 64'h1);
        check("r1_wait_csb", 64'(s2_csb), 64'h3);

        wb_req(1'b1, BASE + 32'h014, 4'b0011, 32'h1234_5678, 1'b0, 1'b0, '0);
        check("w2_wmask", 64'(s1_wmask), 64'h3);
        check("w2_csb", 64'(s1_csb), 64'h2);
        check("w2_wmask_after", 64'(s2_wmask), 64'h0);
        wb_req(1'b0, BASE + 32'h016, 4'h1, '0, 1'b0, 1'b1, 32'h0000_5678);

        wb_req(1'b0, BASE + 32'hC00, 4'hF, '0, 1'b1, 1'b1, 32'h0000_5678);
        check("e1_csb", 64'(s1_csb), 64'h3);
        read_only = 2'b01;
        wb_req(1'b1, BASE + 32'h014, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, '0);
        check("e2_csb", 64'(s1_csb), 64'h3);
        wb_req(1'b0, BASE + 32'h014, 4'hF, '0, 1'b0, 1'b1, 32'h0000_5678);
        wb_req(1'b1, BASE + 32'h408, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b0, '0);
        read_only = 2'b00;
        wb_req(1'b0, BASE + 32'h408, 4'hF, '0, 1'b0, 1'b1, 32'h0BAD_F00D);

        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h1000; sel = 4'hF; dat_i = 32'h5555_5555;
        hold_none("miss_no_resp", 8);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;

        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h404;
        repeat (2) @(negedge clk);
        stb = 1'b0; cyc = 1'b0;
        hold_none("abort_rd_no_resp", 8);

        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h41C; sel = 4'hF; dat_i = 32'hCAFE_F00D;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        hold_none("abort_wr_no_resp", 6);
        wb_req(1'b0, BASE + 32'h41C, 4'h0, '0, 1'b0, 1'b1, 32'hCAFE_F00D);

        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h408; sel = 4'hF; dat_i = 32'hAAAA_5555;
        @(negedge clk);
        check("rsta_csb_before", 64'(ram_csb), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rsta_csb", 64'(ram_csb), 64'h3);
        check("rsta_web", 64'(ram_web), 64'h1);
        check("rsta_wmask", 64'(ram_wmask), 64'h0);
        check("rsta_addr", 64'(ram_addr), 64'h0);
        check("rsta_din", 64'(ram_din), 64'h0);
        check("rsta_dat_o", 64'(dat_o), 64'h0);
        check("rsta_ack_err", {62'd0, ack, err}, 64'h0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        hold_none("rsta_no_resp", 3);
        rst_n = 1'b1;
        wb_req(1'b0, BASE + 32'h404, 4'h0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
